// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions: memory opcodes, memory-stage FSM encoding,
// byte-enable patterns and the access-size decode used by the memory stage.
package cpu_defs;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Unknown opcodes fall through to a word access.
    function automatic size_t access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: access_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: access_size = SZ_HALF;
            OP_LW, OP_SW:         access_size = SZ_WORD;
            default:              access_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/stage_4_mem_load_extend.sv
// Load lane selection and sign/zero extension for the memory stage.
module load_extend
    import cpu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  op,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (op)
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'h0, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'h0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/stage_4_mem.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack bus with timeout.
// Optional misaligned-access trap enabled by defining STAGE4_MISALIGN_CHECK_EN.
module stage_4_mem
    import cpu_defs::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic [31:0] mem_data,
    output logic        mem_done,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    state_t      state, state_nxt;
    size_t       sz;
    logic [15:0] to_cnt;
    logic [5:0]  op_q;
    logic [1:0]  lo_q;
    logic        load_q;
    logic        access, misalign, timeout;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] ext_data;

    assign access  = mem_read | mem_write;
    assign sz      = access_size(op);
    assign timeout = (to_cnt == 16'(ACK_TIMEOUT - 1));

`ifdef STAGE4_MISALIGN_CHECK_EN
    assign misalign = ((sz == SZ_HALF) && alu_result[0]) ||
                      ((sz == SZ_WORD) && (alu_result[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Stores replicate the operand across lanes; the byte enables pick the lane.
    always_comb begin
        be_nxt    = BE_WORD;
        wdata_nxt = store_data;
        if (mem_write) begin
            case (sz)
                SZ_BYTE: begin
                    be_nxt    = BE_BYTE0 << alu_result[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    be_nxt    = alu_result[1] ? BE_HALF_HI : BE_HALF_LO;
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata (dmem_rdata),
        .addr  (lo_q),
        .op    (op_q),
        .ext   (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (access) state_nxt = misalign ? ST_DONE : ST_BUSY;
            ST_BUSY: if (dmem_ack || timeout) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_req = (state == ST_BUSY);
        mem_done = (state == ST_DONE);
        stall    = ((state == ST_IDLE) && access) || (state == ST_BUSY);
    end

    // Ack wins over a timeout landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data   <= '0;
            addr_err   <= 1'b0;
            bus_err    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            to_cnt     <= '0;
            op_q       <= '0;
            lo_q       <= '0;
            load_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        addr_err <= misalign;
                        bus_err  <= 1'b0;
                        to_cnt   <= '0;
                        if (!misalign) begin
                            dmem_addr  <= {alu_result[31:2], 2'b00};
                            dmem_be    <= be_nxt;
                            dmem_wdata <= wdata_nxt;
                            dmem_we    <= mem_write;
                            op_q       <= op;
                            lo_q       <= alu_result[1:0];
                            load_q     <= ~mem_write;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack) begin
                        if (load_q) mem_data <= ext_data;
                    end else if (timeout) begin
                        bus_err  <= 1'b1;
                        mem_data <= '0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_4_mem.sv
// Scoreboard bench for stage_4_mem with a scripted req/ack memory responder.
module tb_stage_4_mem;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] alu_result = '0, store_data = '0;
    logic [31:0] mem_data;
    logic        mem_done, stall, addr_err, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    stage_4_mem #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .op(op),
        .alu_result(alu_result), .store_data(store_data), .mem_data(mem_data),
        .mem_done(mem_done), .stall(stall), .addr_err(addr_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        ae;
        logic        be;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int ack_wait = 0;
    logic [31:0] rdata_val = '0;
    int busy_cnt = 0;
    int last_req_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, want);
        end
    endtask

    // Memory model: acks after ack_wait request cycles (never if negative).
    always @(negedge clk) begin
        if (dmem_req) begin
            if (ack_wait >= 0 && busy_cnt == ack_wait) begin
                dmem_ack   <= 1'b1;
                dmem_rdata <= rdata_val;
            end else begin
                dmem_ack   <= 1'b0;
                dmem_rdata <= 32'hDEAD_DEAD;
            end
            busy_cnt <= busy_cnt + 1;
        end else begin
            if (busy_cnt != 0) last_req_len <= busy_cnt;
            busy_cnt   <= 0;
            dmem_ack   <= 1'b0;
            dmem_rdata <= 32'hDEAD_DEAD;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && mem_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=1 want=0");
            end else begin
                e = exp_q.pop_front();
                check("mem_data", mem_data, e.data);
                check("addr_err", {31'b0, addr_err}, {31'b0, e.ae});
                check("bus_err", {31'b0, bus_err}, {31'b0, e.be});
            end
        end
    end

    task automatic do_access(
        input string name, input logic rd, input logic wr, input logic [5:0] o,
        input logic [31:0] a, input logic [31:0] sd, input int wt, input logic [31:0] rd_val,
        input logic [31:0] e_data, input logic e_ae, input logic e_be,
        input logic e_req, input logic [31:0] e_addr, input logic [3:0] e_ben,
        input logic e_we, input logic [31:0] e_wdata, input int e_lat);
        exp_t e;
        int lat;
        @(negedge clk);
        ack_wait  = wt;
        rdata_val = rd_val;
        mem_read = rd; mem_write = wr; op = o; alu_result = a; store_data = sd;
        e.data = e_data; e.ae = e_ae; e.be = e_be;
        exp_q.push_back(e);
        #1;
        check({name, ".stall0"}, {31'b0, stall}, 32'd1);
        @(negedge clk);
        check({name, ".req"}, {31'b0, dmem_req}, {31'b0, e_req});
        check({name, ".stall1"}, {31'b0, stall}, {31'b0, e_req});
        if (e_req) begin
            check({name, ".addr"}, dmem_addr, e_addr);
            check({name, ".be"}, {28'b0, dmem_be}, {28'b0, e_ben});
            check({name, ".we"}, {31'b0, dmem_we}, {31'b0, e_we});
            if (e_we) check({name, ".wdata"}, dmem_wdata, e_wdata);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        lat = 1;
        while (!mem_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, ".latency"}, lat, e_lat);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.mem_data", mem_data, 32'h0);
        check("rst.flags", {26'b0, mem_done, stall, addr_err, bus_err, dmem_req, dmem_we}, 32'h0);
        check("rst.addr", dmem_addr, 32'h0);
        check("rst.wdata", dmem_wdata, 32'h0);
        check("rst.be", {28'b0, dmem_be}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.stall", {31'b0, stall}, 32'd0);

        //        name    rd  wr  op      addr          sdata         wt  rdata          data          ae    be    req   addr          be       we    wdata         lat
        do_access("sw",   0,  1, OP_SW,  32'h100, 32'hDEADBEEF,  0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 2);
        do_access("lb",   1,  0, OP_LB,  32'h103, 32'h0,         0, 32'h80FFFF7F, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        2);
        do_access("lbu",  1,  0, OP_LBU, 32'h103, 32'h0,         0, 32'h80FFFF7F, 32'h00000080, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        2);
        do_access("sh",   0,  1, OP_SH,  32'h102, 32'h1234ABCD,  0, 32'h0,        32'h00000080, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 2);
        do_access("lhu",  1,  0, OP_LHU, 32'h102, 32'h0,         0, 32'hBEEF0000, 32'h0000BEEF, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        2);
        do_access("lh",   1,  0, OP_LH,  32'h100, 32'h0,         2, 32'h00008001, 32'hFFFF8001, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        4);
        do_access("sb",   0,  1, OP_SB,  32'h101, 32'h123456A5,  0, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 1'b1, 32'h100, 4'b0010, 1'b1, 32'hA5A5A5A5, 2);
        do_access("lw_lastack", 1, 0, OP_LW, 32'h104, 32'h0,     3, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h104, 4'b1111, 1'b0, 32'h0,        5);
        do_access("lw_timeout", 1, 0, OP_LW, 32'h108, 32'h0,    -1, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h108, 4'b1111, 1'b0, 32'h0,        5);
        check("timeout.req_len", last_req_len, 4);
        do_access("lbu_b0", 1,  0, OP_LBU, 32'h10C, 32'h0,       0, 32'h000000FE, 32'h000000FE, 1'b0, 1'b0, 1'b1, 32'h10C, 4'b1111, 1'b0, 32'h0,        2);
`ifdef STAGE4_MISALIGN_CHECK_EN
        do_access("lw_mis", 1,  0, OP_LW,  32'h101, 32'h0,       0, 32'h11223344, 32'h000000FE, 1'b1, 1'b0, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,        1);
`else
        do_access("lw_mis", 1,  0, OP_LW,  32'h101, 32'h0,       0, 32'h11223344, 32'h11223344, 1'b0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        2);
`endif
        do_access("op_other", 1, 0, 6'h3F, 32'h200, 32'h0,      0, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 32'h200, 4'b1111, 1'b0, 32'h0,        2);
        do_access("rd_wr",  1,  1, OP_SW,  32'h110, 32'h0BADF00D, 0, 32'h0,       32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 32'h110, 4'b1111, 1'b1, 32'h0BADF00D, 2);

        // Reset in the middle of a bus access
        @(negedge clk);
        ack_wait = -1;
        mem_read = 1'b1; op = OP_LW; alu_result = 32'h300;
        @(negedge clk);
        check("midrst.req_before", {31'b0, dmem_req}, 32'd1);
        mem_read = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst.req_after", {31'b0, dmem_req}, 32'd0);
        check("midrst.stall", {31'b0, stall}, 32'd0);
        check("midrst.mem_data", mem_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_access("lw_after_rst", 1, 0, OP_LW, 32'h300, 32'h0,  0, 32'h5555AAAA, 32'h5555AAAA, 1'b0, 1'b0, 1'b1, 32'h300, 4'b1111, 1'b0, 32'h0,        2);

        repeat (3) @(negedge clk);
        check("scoreboard.empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
